spi_reg_config: RTL and testbench
=================================

SPI_REG_CONFIG -- requirements
Module: spi_reg_config

Interface
REQ-001 Parameter SYNC_STAGES, default 2, meaning number of flip-flop stages in each input synchronizer (legal values 2..3).
REQ-002 Parameter MAX_ADDR, default 7'h04, meaning highest writable register address.
REQ-003 clk  input  1  meaning system clock; the block has one clock and all state is clocked on its rising edge.
REQ-004 rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 sclk  input  1  meaning SPI serial clock, asynchronous to clk.
REQ-006 copi  input  1  meaning SPI controller-out/peripheral-in data, asynchronous to clk.
REQ-007 ncs  input  1  meaning SPI chip select, active low, asynchronous to clk.
REQ-008 en_reg_out_7_0  output  8  meaning output enables for PWM channels 7..0 (address 0x00).
REQ-009 en_reg_out_15_8  output  8  meaning output enables for PWM channels 15..8 (address 0x01).
REQ-010 en_reg_pwm_7_0  output  8  meaning PWM-mode enables for channels 7..0 (address 0x02).
REQ-011 en_reg_pwm_15_8  output  8  meaning PWM-mode enables for channels 15..8 (address 0x03).
REQ-012 pwm_duty_cycle  output  8  meaning shared PWM duty-cycle value (address 0x04).

Function
REQ-013 The block SHALL pass sclk, copi and ncs each through a SYNC_STAGES-deep synchronizer and SHALL NOT use the raw pins in any other logic.
REQ-014 The block SHALL detect sclk rising, ncs falling and ncs rising edges by comparing the last synchronizer stage with one additional registered copy.
REQ-015 The protocol SHALL be SPI mode 0, MSB first: copi sampled on each synchronized sclk rising edge while synchronized ncs is low.
REQ-016 A frame SHALL be 16 bits: bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
REQ-017 The FSM SHALL have states IDLE, SHIFT and COMMIT.
REQ-018 IDLE -> SHIFT on ncs falling edge; the 16-bit shift register and 5-bit bit counter SHALL be cleared on that transition.
REQ-019 In SHIFT, each sclk rising edge SHALL shift copi into bit 0 and increment the counter; the counter SHALL saturate at 17 (meaning "more than 16 bits").
REQ-020 SHIFT -> COMMIT on ncs rising edge; COMMIT -> IDLE unconditionally after one clk cycle.
REQ-021 In COMMIT, the addressed register SHALL be written with the data byte only if counter == 16, R/W == 1 and address <= MAX_ADDR; otherwise no register SHALL change.
REQ-022 Frames with fewer or more than 16 bits, read frames (R/W = 0) and out-of-range addresses SHALL be discarded silently.
REQ-023 A written value SHALL be visible on its output on the clk edge that ends COMMIT, i.e. SYNC_STAGES + 2 clk cycles after the ncs pin rises.
REQ-024 Outputs SHALL be driven directly from registers and SHALL hold their value between writes.
REQ-025 sclk edges while ncs is high SHALL be ignored; an ncs falling edge received in COMMIT SHALL be ignored (minimum ncs-high time is 3 clk cycles).
REQ-026 sclk high and low phases SHALL each be at least SYNC_STAGES + 1 clk periods; behaviour for faster sclk is undefined.

Reset
REQ-027 While rst_n is low, all five output registers SHALL be 8'h00, the FSM SHALL be IDLE, and the shift register, counter and all synchronizer/edge flops SHALL be cleared (ncs synchronizer stages SHALL reset to 1).
REQ-028 Reset asserted mid-frame SHALL abort the frame with no register write.
REQ-029 If ncs is low when rst_n is released, no frame SHALL start until ncs has gone high and then low again.

Verification
REQ-030 Write 0x00 <- 8'hA5 (frame 16'h80A5) -> en_reg_out_7_0 == 8'hA5 within SYNC_STAGES+2 clk cycles of ncs rising; all other outputs 8'h00.
REQ-031 Write 0x04 <- 8'h80, then 0x02 <- 8'hFF -> pwm_duty_cycle == 8'h80 and en_reg_pwm_7_0 == 8'hFF; values hold across 100 idle cycles.
REQ-032 Read frame 16'h0155 and write to address 0x05 (16'h8555) -> no output changes.
REQ-033 Write 0x01 <- 8'h3C sent with 15 bits, then with 17 bits -> en_reg_out_15_8 unchanged (8'h00) in both cases.
REQ-034 Assert rst_n low after 8 bits of frame 16'h83FF, release with ncs still low, finish clocking -> en_reg_pwm_15_8 == 8'h00; next clean frame 16'h83FF -> 8'hFF.
REQ-035 Toggle sclk 20 times with ncs high, then send 16'h8412 -> only pwm_duty_cycle == 8'h12; no spurious writes.

Source files
------------

// File: rtl/spi_reg_config.sv
// SPI mode-0 write-only configuration port: 16-bit frames {W, addr[6:0], data[7:0]}
// update five 8-bit enable/duty registers; everything is resynchronised into clk.
module spi_reg_config #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_copi_sync;
   logic [SYNC_STAGES-1:0] r_ncs_sync;
   logic                   r_sclk_d;
   logic                   r_ncs_d;
   logic [SYNC_STAGES:0]   r_flush;
   logic                   r_ncs_armed;

   logic [15:0]            r_shift;
   logic [4:0]             r_cnt;

   logic                   w_sclk_s;
   logic                   w_copi_s;
   logic                   w_ncs_s;
   logic                   w_sclk_rise;
   logic                   w_ncs_fall;
   logic                   w_ncs_rise;
   logic                   w_start;
   logic                   w_write;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
   assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
   assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;

   // A frame may only start once ncs has been seen high through a fully flushed
   // synchronizer, so a chip select held low across reset release cannot start one.
   assign w_start     = w_ncs_fall & r_ncs_armed;

   assign w_write     = (r_state == ST_COMMIT) && (r_cnt == 5'd16) &&
                        r_shift[15] && (r_shift[14:8] <= MAX_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_copi_sync <= '0;
         r_ncs_sync  <= '1;
         r_sclk_d    <= 1'b0;
         r_ncs_d     <= 1'b1;
         r_flush     <= '0;
         r_ncs_armed <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
         r_sclk_d    <= w_sclk_s;
         r_ncs_d     <= w_ncs_s;
         r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
         r_ncs_armed <= r_ncs_armed | (r_flush[SYNC_STAGES] & r_ncs_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_start)    w_state_nxt = ST_SHIFT;
         ST_SHIFT:  if (w_ncs_rise) w_state_nxt = ST_COMMIT;
         ST_COMMIT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if ((r_state == ST_IDLE) && w_start) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if ((r_state == ST_SHIFT) && w_sclk_rise) begin
         r_shift <= {r_shift[14:0], w_copi_s};
         // 17 is sticky and means "too many bits"
         r_cnt   <= (r_cnt >= 5'd17) ? 5'd17 : r_cnt + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_reg_out_7_0  <= 8'h00;
         en_reg_out_15_8 <= 8'h00;
         en_reg_pwm_7_0  <= 8'h00;
         en_reg_pwm_15_8 <= 8'h00;
         pwm_duty_cycle  <= 8'h00;
      end else if (w_write) begin
         case (r_shift[14:8])
            7'd0:    en_reg_out_7_0  <= r_shift[7:0];
            7'd1:    en_reg_out_15_8 <= r_shift[7:0];
            7'd2:    en_reg_pwm_7_0  <= r_shift[7:0];
            7'd3:    en_reg_pwm_15_8 <= r_shift[7:0];
            7'd4:    pwm_duty_cycle  <= r_shift[7:0];
            default: ;
         endcase
      end
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_reg_config.sv
// Bench for spi_reg_config: directed frame table, multi-cycle corner sequences and
// random frames compared against a register-file model of the frame rules.
module tb_spi_reg_config;

   localparam int SYNC = 2;

   logic       clk;
   logic       rst_n;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic [1:0] o_dbg_state;
   logic [39:0] dut_vec;

   int checks = 0;
   int errors = 0;

   spi_reg_config #(
      .SYNC_STAGES (SYNC),
      .MAX_ADDR    (7'h04)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .o_dbg_state     (o_dbg_state)
   );

   // register at address a lives in dut_vec[8*a +: 8]
   assign dut_vec = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                     en_reg_out_15_8, en_reg_out_7_0};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] bits;
      int          nbits;
      logic [39:0] exp;
   } vec_t;

   vec_t tbl[7];

   function automatic logic [39:0] model_apply(input logic [39:0] cur,
                                               input logic [31:0] bits,
                                               input int nbits);
      logic [15:0] f;
      int          addr;
      logic [39:0] nxt;
      f    = bits[15:0];
      addr = int'(f[14:8]);
      nxt  = cur;
      if (nbits == 16 && f[15] && addr <= 4) nxt[8*addr +: 8] = f[7:0];
      return nxt;
   endfunction

   task automatic check_regs(input string name, input logic [39:0] exp);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (dut_vec[8*i +: 8] !== exp[8*i +: 8]) begin
            errors++;
            $display("FAIL %s reg%0d got %02h expected %02h", name, i,
                     dut_vec[8*i +: 8], exp[8*i +: 8]);
         end
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (o_dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL %s state got %0d expected 0", name, o_dbg_state);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ncs   = 1'b1;
      sclk  = 1'b0;
      copi  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic spi_start();
      @(negedge clk);
      ncs = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [31:0] bits, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = bits[i];
         repeat (5) @(negedge clk);
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   // Raise ncs, check the old value one cycle before the commit edge and the new
   // value right after it (SYNC+2 cycles after the pin rises).
   task automatic end_and_check(input string name, input logic [39:0] old_v,
                                input logic [39:0] new_v);
      repeat (2) @(negedge clk);
      ncs = 1'b1;
      repeat (SYNC + 1) @(posedge clk);
      @(negedge clk);
      check_regs({name, "_early"}, old_v);
      @(posedge clk);
      @(negedge clk);
      check_regs(name, new_v);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [39:0] prev;
      logic [39:0] model;
      logic [15:0] f16;
      logic [31:0] bits;
      int          nb;
      int          sel;

      tbl[0] = '{32'h0000_80A5, 16, 40'h00_00_00_00_A5};
      tbl[1] = '{32'h0000_8480, 16, 40'h80_00_00_00_A5};
      tbl[2] = '{32'h0000_82FF, 16, 40'h80_00_FF_00_A5};
      tbl[3] = '{32'h0000_0155, 16, 40'h80_00_FF_00_A5};
      tbl[4] = '{32'h0000_8555, 16, 40'h80_00_FF_00_A5};
      tbl[5] = '{32'h0000_409E, 15, 40'h80_00_FF_00_A5};
      tbl[6] = '{32'h0001_0278, 17, 40'h80_00_FF_00_A5};

      rst_n = 1'b0;
      sclk  = 1'b0;
      copi  = 1'b0;
      ncs   = 1'b1;
      repeat (3) @(negedge clk);
      check_regs("reset", 40'h0);
      check_idle("reset");
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      prev = 40'h0;
      for (int i = 0; i < 7; i++) begin
         spi_start();
         spi_bits(tbl[i].bits, tbl[i].nbits);
         end_and_check($sformatf("vec%0d", i), prev, tbl[i].exp);
         prev = tbl[i].exp;
      end
      repeat (100) @(negedge clk);
      check_regs("hold100", prev);

      // reset in the middle of a frame, released with ncs still low
      do_reset();
      spi_start();
      spi_bits(32'h83, 8);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_regs("midreset", 40'h0);
      check_idle("midreset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      spi_bits(32'hFF, 8);
      end_and_check("aborted", 40'h0, 40'h0);
      spi_start();
      spi_bits(32'h83FF, 16);
      end_and_check("clean83ff", 40'h0, 40'h00_FF_00_00_00);

      // sclk activity while deselected must not disturb the next frame
      do_reset();
      for (int i = 0; i < 20; i++) begin
         copi = 1'($urandom_range(0, 1));
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
         repeat (5) @(negedge clk);
      end
      check_regs("sclk_noncs", 40'h0);
      spi_start();
      spi_bits(32'h8412, 16);
      end_and_check("after_toggle", 40'h0, 40'h12_00_00_00_00);

      model = 40'h12_00_00_00_00;
      for (int n = 0; n < 40; n++) begin
         f16 = {1'($urandom_range(0, 3) != 0), 4'h0,
                3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
         sel = $urandom_range(0, 5);
         if (sel == 0) begin
            nb   = 15;
            bits = {17'h0, f16[15:1]};
         end else if (sel == 1) begin
            nb   = 17;
            bits = {15'h0, f16, 1'($urandom_range(0, 1))};
         end else begin
            nb   = 16;
            bits = {16'h0, f16};
         end
         prev  = model;
         model = model_apply(model, {16'h0, f16}, nb);
         spi_start();
         spi_bits(bits, nb);
         end_and_check($sformatf("rand%0d", n), prev, model);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
